// File: rtl/uart_cmd_switch_bank_if.sv
// Byte-in / switch-state-out bundle between the UART receiver side and the switch bank.
// The master side feeds received bytes; the slave side (the switch bank) drives the results.
interface uart_cmd_switch_bank_if #(
  parameter int CH_NUM = 4
);
  logic [7:0]        po_data;
  logic              rx_down;
  logic [CH_NUM-1:0] ch_state;
  logic [CH_NUM-1:0] rise_pulse;
  logic [CH_NUM-1:0] fall_pulse;
  logic              cmd_ack;
  logic              cmd_err;

  modport master (
    output po_data, rx_down,
    input  ch_state, rise_pulse, fall_pulse, cmd_ack, cmd_err
  );

  modport slave (
    input  po_data, rx_down,
    output ch_state, rise_pulse, fall_pulse, cmd_ack, cmd_err
  );
endinterface

// File: rtl/uart_cmd_switch_bank.sv
// Multi-channel switch bank driven by two-byte ASCII commands <channel letter><op>.
// An op of '1' sets, '0' clears and 'T' toggles the latched channel; bad or late input raises cmd_err.
module uart_cmd_switch_bank #(
  parameter int                  CH_NUM      = 4,
  parameter logic [8*CH_NUM-1:0] CH_CHARS    = "RQPN",
  parameter int                  TIMEOUT_CYC = 500000
) (
  input logic                   clk,
  input logic                   rst_n,
  uart_cmd_switch_bank_if.slave bus
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_CLR = 8'h30;
  localparam logic [7:0] OP_SET = 8'h31;
  localparam logic [7:0] OP_TGL = 8'h54;

  typedef enum logic {IDLE, WAIT_OP} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [TO_W-1:0]   cnt_q, cnt_n;
  logic [CH_NUM-1:0] ch_q, ch_n, ch_d;
  logic [CH_NUM-1:0] rise_q, fall_q;
  logic              ack_q, ack_n, err_q, err_n;

  logic              is_letter, is_op;
  logic [IDX_W-1:0]  letter_idx;

  // Letter lookup scans downward so the lowest matching channel index wins.
  always_comb begin
    is_letter  = 1'b0;
    letter_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (bus.po_data == CH_CHARS[8*i +: 8]) begin
        is_letter  = 1'b1;
        letter_idx = IDX_W'(i);
      end
    end
    is_op = (bus.po_data == OP_CLR) || (bus.po_data == OP_SET) || (bus.po_data == OP_TGL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // An op byte takes priority over a letter in WAIT_OP, so ops are never mistaken for a resync.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.rx_down && is_letter) state_n = WAIT_OP;
      end
      WAIT_OP: begin
        if (bus.rx_down) begin
          if (is_op)          state_n = IDLE;
          else if (is_letter) state_n = WAIT_OP;
          else                state_n = IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ack_n = 1'b0;
    err_n = 1'b0;
    ch_n  = ch_q;
    idx_n = idx_q;
    cnt_n = cnt_q;
    unique case (state)
      IDLE: begin
        if (bus.rx_down) begin
          if (is_letter) begin
            idx_n = letter_idx;
            cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WAIT_OP: begin
        if (bus.rx_down) begin
          if (is_op) begin
            ack_n = 1'b1;
            for (int i = 0; i < CH_NUM; i++) begin
              if (idx_q == IDX_W'(i)) begin
                if (bus.po_data == OP_SET)      ch_n[i] = 1'b1;
                else if (bus.po_data == OP_CLR) ch_n[i] = 1'b0;
                else                            ch_n[i] = ~ch_q[i];
              end
            end
          end else if (is_letter) begin
            err_n = 1'b1;
            idx_n = letter_idx;
            cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          err_n = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Edge pulses compare ch_state against its one-cycle-delayed copy, so they trail the change by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      ch_q   <= '0;
      ch_d   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_n;
      cnt_q  <= cnt_n;
      ch_q   <= ch_n;
      ch_d   <= ch_q;
      rise_q <= ch_q & ~ch_d;
      fall_q <= ~ch_q & ch_d;
      ack_q  <= ack_n;
      err_q  <= err_n;
    end
  end

  assign bus.ch_state   = ch_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.cmd_ack    = ack_q;
  assign bus.cmd_err    = err_q;

endmodule

// File: tb/tb_uart_cmd_switch_bank.sv
// Directed bench for uart_cmd_switch_bank: a vector table for single-cycle behaviour
// plus hand-written sequences for timeout and mid-command reset.
module tb_uart_cmd_switch_bank;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  uart_cmd_switch_bank_if #(.CH_NUM(4)) bus();

  uart_cmd_switch_bank #(
    .CH_NUM(4),
    .CH_CHARS("RQPN"),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rx;
    logic [7:0] data;
    logic [3:0] ch;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       ack;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic rx, input logic [7:0] data);
    @(negedge clk);
    bus.rx_down = rx;
    bus.po_data = data;
    @(posedge clk);
    #1;
    bus.rx_down = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ch, input logic [3:0] rise,
                             input logic [3:0] fall, input logic ack, input logic err);
    logic [13:0] act, exp;
    act = {bus.ch_state, bus.rise_pulse, bus.fall_pulse, bus.cmd_ack, bus.cmd_err};
    exp = {ch, rise, fall, ack, err};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got ch=%b rise=%b fall=%b ack=%b err=%b, want ch=%b rise=%b fall=%b ack=%b err=%b",
               name, act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic vec_t mk(input logic rx, input logic [7:0] d, input logic [3:0] ch,
                              input logic [3:0] r, input logic [3:0] f, input logic a, input logic e);
    vec_t v;
    v.rx = rx; v.data = d; v.ch = ch; v.rise = r; v.fall = f; v.ack = a; v.err = e;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    bus.rx_down = 1'b0;
    bus.po_data = 8'h00;
    rst_n = 1'b0;

    // rx, data, ch, rise, fall, ack, err  (outputs expected just after that cycle's edge)
    vecs.push_back(mk(1, "N",   4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "1",   4'b0001, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0001, 4'b0001, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0001, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "P",   4'b0001, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "1",   4'b0011, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0011, 4'b0010, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "P",   4'b0011, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "T",   4'b0001, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(1, "P",   4'b0001, 4'b0000, 4'b0010, 0, 0));
    vecs.push_back(mk(1, "T",   4'b0011, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0011, 4'b0010, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "N",   4'b0011, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "P",   4'b0011, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(1, "0",   4'b0001, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0001, 4'b0000, 4'b0010, 0, 0));
    vecs.push_back(mk(1, "Q",   4'b0001, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "1",   4'b0101, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0101, 4'b0100, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "X",   4'b0101, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(1, "Q",   4'b0101, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "1",   4'b0101, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b0101, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "0",   4'b0101, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(1, "R",   4'b0101, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "Z",   4'b0101, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(1, "1",   4'b0101, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(1, "R",   4'b0101, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "1",   4'b1101, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(1, "N",   4'b1101, 4'b1000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, "T",   4'b1100, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 8'h00, 4'b1100, 4'b0000, 4'b0001, 0, 0));
    vecs.push_back(mk(0, "N",   4'b1100, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, "1",   4'b1100, 4'b0000, 4'b0000, 0, 0));

    #12;
    checkOutput("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rx, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].ch, vecs[i].rise, vecs[i].fall,
                  vecs[i].ack, vecs[i].err);
    end

    // Timeout: letter, then TO-1 quiet cycles with no error, error on cycle TO, then quiet again.
    applyStimulus(1'b1, "N");
    for (int i = 1; i < TO; i++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("to_wait%0d", i), 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("to_expire", 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("to_after", 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, "1");
    checkOutput("to_stray_op", 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b1);

    // Op byte landing exactly on the expiry cycle wins over the timeout.
    applyStimulus(1'b1, "N");
    for (int i = 1; i < TO; i++) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, "1");
    checkOutput("to_byte_wins", 4'b1101, 4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("to_byte_rise", 4'b1101, 4'b0001, 4'b0000, 1'b0, 1'b0);

    // Reset between letter and op discards the pending command.
    applyStimulus(1'b1, "R");
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, "1");
    checkOutput("post_reset_op", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("post_reset_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
